// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
//   Stall/flush controller for the 5-stage core. It handles the hazards that
//   EX forwarding cannot cover:
//   - load-use: freeze PC and IF/ID, and inject an ID/EX bubble;
//   - slow data memory: hold the whole pipeline until dmem ready, and abort
//     after TIMEOUT wait cycles;
//   - taken branch: flush IF/ID and ID/EX.
//   It also keeps a saturating stall-cycle counter and a sticky timeout flag.
//
// Ports
//   i_clk, i_rst_n      clock, async active-low reset
//   i_ifid_rs1/rs2      source regs of the instruction in ID
//   i_idex_rd           dest reg of the instruction in EX
//   i_idex_memread      EX instruction is a load
//   i_exmem_memread     MEM-stage load
//   i_exmem_memwrite    MEM-stage store
//   i_dmem_ready        data memory completes its access this cycle
//   i_branch_taken      EX resolved a taken branch/jump
//   o_pc_write          PC update enable
//   o_ifid_write        IF/ID enable
//   o_idex_bubble       load NOP into ID/EX
//   o_ifid_flush        load NOP into IF/ID
//   o_exmem_hold        freeze EX/MEM, MEM/WB, ID/EX
//   o_stall_count       cycles with pc_write low (saturating)
//   o_mem_err           sticky memory-timeout flag
// ---------------------------------------------------------------------------
module hazard_stall_ctrl #(
  parameter int REG_WIDTH = 5,
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [REG_WIDTH-1:0] i_ifid_rs1,
  input  logic [REG_WIDTH-1:0] i_ifid_rs2,
  input  logic [REG_WIDTH-1:0] i_idex_rd,
  input  logic                 i_idex_memread,
  input  logic                 i_exmem_memread,
  input  logic                 i_exmem_memwrite,
  input  logic                 i_dmem_ready,
  input  logic                 i_branch_taken,
  output logic                 o_pc_write,
  output logic                 o_ifid_write,
  output logic                 o_idex_bubble,
  output logic                 o_ifid_flush,
  output logic                 o_exmem_hold,
  output logic [CNT_WIDTH-1:0] o_stall_count,
  output logic                 o_mem_err
);

  localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ABORT} state_t;

  state_t               r_state, w_state_nxt;
  logic [WC_W-1:0]      r_wait_cnt, w_wait_cnt_nxt;
  logic                 r_mem_err, w_mem_err_nxt;
  logic [CNT_WIDTH-1:0] r_stall_cnt;

  logic w_mem_acc, w_lu, w_hold;
  logic w_pc_write, w_ifid_write, w_idex_bubble, w_ifid_flush, w_exmem_hold;

  assign w_mem_acc = i_exmem_memread | i_exmem_memwrite;
  assign w_lu      = i_idex_memread && (i_idex_rd != '0) &&
                     ((i_idex_rd == i_ifid_rs1) || (i_idex_rd == i_ifid_rs2));
  // ABORT lets the timed-out access retire, even if it still looks pending.
  assign w_hold    = (r_state != ABORT) && w_mem_acc && !i_dmem_ready;

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_mem_err  <= w_mem_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_mem_err_nxt  = r_mem_err;
    case (r_state)
      RUN: begin
        if (w_mem_acc && !i_dmem_ready) begin
          w_state_nxt    = MEM_WAIT;
          w_wait_cnt_nxt = '0;
        end
      end
      MEM_WAIT: begin
        if (i_dmem_ready) begin
          w_state_nxt = RUN;
        end else if (r_wait_cnt == WC_LAST) begin
          w_state_nxt   = ABORT;
          w_mem_err_nxt = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 1'b1;
        end
      end
      ABORT:   w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output rules, in priority order: hold, branch, load-use, default.
  // Reset forces a safe "squash everything" pattern asynchronously.
  // -------------------------------------------------------------------------
  always_comb begin
    w_pc_write    = 1'b1;
    w_ifid_write  = 1'b1;
    w_idex_bubble = 1'b0;
    w_ifid_flush  = 1'b0;
    w_exmem_hold  = 1'b0;
    if (!i_rst_n) begin
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
      w_idex_bubble = 1'b1;
      w_ifid_flush  = 1'b1;
    end else if (w_hold) begin
      // Branch and load-use wait: EX is frozen, so their inputs stay put.
      w_exmem_hold  = 1'b1;
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
    end else if (i_branch_taken) begin
      // The dependent instruction is squashed, so load-use does not matter.
      w_ifid_flush  = 1'b1;
      w_idex_bubble = 1'b1;
    end else if (w_lu) begin
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
      w_idex_bubble = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Saturating stall counter
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_stall_cnt <= '0;
    else if (!w_pc_write && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign o_pc_write    = w_pc_write;
  assign o_ifid_write  = w_ifid_write;
  assign o_idex_bubble = w_idex_bubble;
  assign o_ifid_flush  = w_ifid_flush;
  assign o_exmem_hold  = w_exmem_hold;
  assign o_stall_count = r_stall_cnt;
  assign o_mem_err     = r_mem_err;

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline stall and flush controller for the 5-stage core. It is the upstream counterpart of the EX-stage forwarding unit and resolves the hazards that forwarding cannot cover:

- **Load-use:** it freezes PC/IF-ID and injects an ID/EX bubble.
- **Slow data memory:** it holds the whole pipeline until `dmem_ready`, with a timeout abort.
- **Taken branches:** it flushes IF/ID and ID/EX.

It also keeps a saturating stall-cycle counter and a sticky memory-timeout error flag.

## Interface
Parameters:
- `REG_WIDTH`, 5, register index width
- `CNT_WIDTH`, 16, stall counter width
- `TIMEOUT`, 16, max cycles in MEM_WAIT before abort (≥2)

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `ifid_rs1`  in  REG_WIDTH  rs1 of instruction in ID
- `ifid_rs2`  in  REG_WIDTH  rs2 of instruction in ID
- `idex_rd`  in  REG_WIDTH  rd of instruction in EX
- `idex_memread`  in  1  EX instruction is a load
- `exmem_memread`  in  1  MEM-stage load
- `exmem_memwrite`  in  1  MEM-stage store
- `dmem_ready`  in  1  data memory completes access this cycle
- `branch_taken`  in  1  EX resolved a taken branch/jump
- `pc_write`  out  1  PC update enable
- `ifid_write`  out  1  IF/ID register enable
- `idex_bubble`  out  1  load NOP into ID/EX
- `ifid_flush`  out  1  load NOP into IF/ID
- `exmem_hold`  out  1  freeze EX/MEM, MEM/WB, ID/EX
- `stall_count`  out  CNT_WIDTH  cycles with `pc_write=0`, saturating
- `mem_err`  out  1  sticky: a memory access timed out

## Operation
Derived signals:
- `mem_acc = exmem_memread | exmem_memwrite`
- `lu = idex_memread & (idex_rd != 0) & (idex_rd == ifid_rs1 | idex_rd == ifid_rs2)`

FSM states: RUN, MEM_WAIT, ABORT. Register `wait_cnt` is $clog2(TIMEOUT) bits wide.

State transitions:
- **RUN → MEM_WAIT:** when `mem_acc & !dmem_ready`; `wait_cnt` ← 0.
- **MEM_WAIT → RUN:** when `dmem_ready`.
- **MEM_WAIT → ABORT:** when `!dmem_ready & wait_cnt == TIMEOUT-1`; `mem_err` ← 1.
- **MEM_WAIT, otherwise:** `wait_cnt` increments.
- **ABORT → RUN:** unconditionally, after one cycle.

Output rules, combinational from state and inputs, evaluated in priority order:
1. **Hold:** `(state != ABORT) & mem_acc & !dmem_ready` → `exmem_hold=1`, `pc_write=0`, `ifid_write=0`, `idex_bubble=0`, `ifid_flush=0`. The branch flush and load-use stall are deferred; their inputs stay stable because EX is frozen.
2. **Branch:** `branch_taken` → `ifid_flush=1`, `idex_bubble=1`, `pc_write=1`, `ifid_write=1`. This overrides load-use because the dependent instruction is squashed.
3. **Load-use:** `lu` → `pc_write=0`, `ifid_write=0`, `idex_bubble=1`.
4. **Default:** `pc_write=1`, `ifid_write=1`, all other outputs 0.

In ABORT, `exmem_hold` is forced to 0 so the timed-out instruction retires with undefined load data. Rules 2–4 apply as normal.

Counter:
- `stall_count` increments on each clock edge where `pc_write==0`.
- It holds at all-ones and never wraps.

Error flag:
- `mem_err` clears only on reset.

## Timing
While `rst_n=0`, asynchronously:
- `pc_write=0`, `ifid_write=0`, `idex_bubble=1`, `ifid_flush=1`, `exmem_hold=0`
- `stall_count=0`, `mem_err=0`, state=RUN, `wait_cnt=0`

On release, outputs follow the rules on the next evaluation with no added latency.

Stall latencies:
- Load-use: exactly 1 stall cycle. The bubble advances the load to MEM, so `lu` drops.
- Hold: asserts in the same cycle the access appears in MEM. It drops in the cycle `dmem_ready=1`, so a 0-wait memory causes no stall.
- Maximum hold: TIMEOUT+1 cycles; ABORT follows on the next edge.

Boundary cases:
- **Back-to-back accesses:** a new `mem_acc` with `!dmem_ready` in the cycle after a MEM_WAIT exit re-enters MEM_WAIT.
- **ABORT:** `mem_acc` in ABORT does not re-enter MEM_WAIT. ABORT→RUN is unconditional and the instruction advances.
- **Reset mid-MEM_WAIT:** returns to RUN immediately; no error is recorded.
- **rd = x0:** `idex_rd == 0` never stalls.

## Test plan
- **Load-use:** `idex_memread=1`, `idex_rd=5`, `ifid_rs2=5`, memory ready → exactly one cycle of `pc_write=0`, `ifid_write=0`, `idex_bubble=1`; `stall_count` 0→1.
- **x0 load:** `idex_rd=0`, `ifid_rs1=0`, load in EX → no stall; `pc_write=1` throughout.
- **Branch vs load-use:** `lu` true and `branch_taken=1` in the same cycle → `ifid_flush=1`, `idex_bubble=1`, `pc_write=1`; no stall cycle counted.
- **Memory wait:** `exmem_memread=1`, `dmem_ready` low for 3 cycles then high → `exmem_hold=1` for 3 cycles, released in the ready cycle; `stall_count=3`; `mem_err=0`.
- **Timeout:** `TIMEOUT=4`, `dmem_ready` held low → hold for 5 cycles, then 1 ABORT cycle with hold=0; `mem_err=1` sticky; next access stalls normally.
- **Reset and saturation:** assert `rst_n=0` mid-MEM_WAIT → outputs go to reset values immediately and state is RUN after release. With `CNT_WIDTH=4`, 20 stall cycles → `stall_count` saturates at 15.
